// File: rtl/div32appx_pkg.sv
// Shared definitions for the approximate iterative signed divider.
package div32appx_pkg;

  // Controller states: waiting for operands, iterating, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Saturation values for the 32-bit quotient (overflow and divide-by-zero).
  localparam logic [31:0] QMAX = 32'h7FFF_FFFF;
  localparam logic [31:0] QMIN = 32'h8000_0000;

  // Number of restoring steps actually executed; skipped LSBs are never computed.
  function automatic int calc_iter(input int width, input int appx_bits);
    return width - appx_bits;
  endfunction

endpackage

// File: rtl/div32appx_step.sv
// One combinational restoring-division step on an unsigned partial remainder.
module div32appx_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   p_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   p_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;

  // Shift in the next dividend bit, then subtract the divisor when it fits.
  always_comb begin
    shifted = {p_in, bit_in};
    q_bit   = (shifted >= {2'b00, divisor});
    p_out   = q_bit ? (WIDTH+1)'(shifted - {2'b00, divisor}) : (WIDTH+1)'(shifted);
  end

endmodule

// File: rtl/signed_div32_appx_iter.sv
// Iterative signed divider with optional skipped quotient LSBs.
// Zero operands and a unit divisor finish in a single cycle; everything
// else runs one restoring step per cycle over the top WIDTH-APPX_BITS bits.
module signed_div32_appx_iter
  import div32appx_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int APPX_BITS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int ITER  = calc_iter(WIDTH, APPX_BITS);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Generic-width saturation values; they equal QMAX/QMIN when WIDTH is 32.
  localparam logic [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] LOW_MASK = ~({WIDTH{1'b1}} << APPX_BITS);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ITER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] abs_a_q, abs_a_d;
  logic [WIDTH-1:0] abs_b_q, abs_b_d;
  logic [WIDTH-1:0] div_sh_q, div_sh_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] q_out_q, q_out_d;
  logic [WIDTH-1:0] r_out_q, r_out_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] abs_a_in;
  logic [WIDTH-1:0] abs_b_in;
  logic [WIDTH-1:0] mag_q;
  logic [WIDTH-1:0] mag_r;
  logic [WIDTH:0]   step_p;
  logic             step_bit;

  div32appx_step #(.WIDTH(WIDTH)) u_step (
    .p_in    (p_q),
    .bit_in  (div_sh_q[WIDTH-1]),
    .divisor (abs_b_q),
    .p_out   (step_p),
    .q_bit   (step_bit)
  );

  // Next-state and datapath update: accept/shortcut in IDLE, iterate in CALC, hold in DONE.
  always_comb begin
    state_d  = state_q;
    abs_a_d  = abs_a_q;
    abs_b_d  = abs_b_q;
    div_sh_d = div_sh_q;
    p_d      = p_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    q_out_d  = q_out_q;
    r_out_d  = r_out_q;
    dz_d     = dz_q;
    mag_q    = '0;
    mag_r    = '0;
    abs_a_in = a[WIDTH-1] ? -a : a;
    abs_b_in = b[WIDTH-1] ? -b : b;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          abs_a_d  = abs_a_in;
          abs_b_d  = abs_b_in;
          div_sh_d = abs_a_in;
          q_neg_d  = a[WIDTH-1] ^ b[WIDTH-1];
          r_neg_d  = a[WIDTH-1];
          p_d      = '0;
          quo_d    = '0;
          cnt_d    = CNT_INIT;
          dz_d     = 1'b0;
          if (b == '0) begin
            q_out_d = a[WIDTH-1] ? SAT_MIN : SAT_MAX;
            r_out_d = a;
            dz_d    = 1'b1;
            state_d = DONE;
          end else if (a == '0) begin
            q_out_d = '0;
            r_out_d = '0;
            state_d = DONE;
          end else if (abs_b_in == {{(WIDTH-1){1'b0}}, 1'b1}) begin
            if (!(a[WIDTH-1] ^ b[WIDTH-1]) && abs_a_in[WIDTH-1]) begin
              q_out_d = SAT_MAX;
            end else begin
              q_out_d = (a[WIDTH-1] ^ b[WIDTH-1]) ? -abs_a_in : abs_a_in;
            end
            r_out_d = '0;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        p_d      = step_p;
        quo_d    = WIDTH'({quo_q, step_bit});
        div_sh_d = div_sh_q << 1;
        cnt_d    = cnt_q - CNT_ONE;
        if (cnt_q == '0) begin
          mag_q   = quo_d << APPX_BITS;
          mag_r   = (WIDTH'(step_p) << APPX_BITS) | (abs_a_q & LOW_MASK);
          q_out_d = q_neg_q ? -mag_q : mag_q;
          r_out_d = r_neg_q ? -mag_r : mag_r;
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset that aborts any division.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      abs_a_q  <= '0;
      abs_b_q  <= '0;
      div_sh_q <= '0;
      p_q      <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      q_out_q  <= '0;
      r_out_q  <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      abs_a_q  <= abs_a_d;
      abs_b_q  <= abs_b_d;
      div_sh_q <= div_sh_d;
      p_q      <= p_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      q_out_q  <= q_out_d;
      r_out_q  <= r_out_d;
      dz_q     <= dz_d;
    end
  end

  // Handshake flags are decoded straight from the registered state.
  always_comb begin
    in_ready    = (state_q == IDLE);
    out_valid   = (state_q == DONE);
    q           = q_out_q;
    r           = r_out_q;
    div_by_zero = dz_q;
  end

endmodule

// File: tb/tb_signed_div32_appx_iter.sv
// Self-checking bench: directed cases plus random operands against a plain
// integer-arithmetic reference, on an exact and a 4-LSB-approximate instance.
module tb_signed_div32_appx_iter;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic        outReady;
  logic        useAppx;
  logic [31:0] aDrv;
  logic [31:0] bDrv;

  logic        inValid0, inReady0, outValid0, outReady0, dz0;
  logic [31:0] q0, r0;
  logic        inValid4, inReady4, outValid4, outReady4, dz4;
  logic [31:0] q4, r4;

  logic        curInReady, curOutValid, curDz;
  logic [31:0] curQ, curR;

  int checks;
  int errors;

  signed_div32_appx_iter #(.WIDTH(32), .APPX_BITS(0)) dut0 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (inValid0),
    .in_ready    (inReady0),
    .a           (aDrv),
    .b           (bDrv),
    .out_valid   (outValid0),
    .out_ready   (outReady0),
    .q           (q0),
    .r           (r0),
    .div_by_zero (dz0)
  );

  signed_div32_appx_iter #(.WIDTH(32), .APPX_BITS(4)) dut4 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (inValid4),
    .in_ready    (inReady4),
    .a           (aDrv),
    .b           (bDrv),
    .out_valid   (outValid4),
    .out_ready   (outReady4),
    .q           (q4),
    .r           (r4),
    .div_by_zero (dz4)
  );

  assign inValid0    = inValid & ~useAppx;
  assign inValid4    = inValid & useAppx;
  assign outReady0   = outReady & ~useAppx;
  assign outReady4   = outReady & useAppx;
  assign curInReady  = useAppx ? inReady4 : inReady0;
  assign curOutValid = useAppx ? outValid4 : outValid0;
  assign curQ        = useAppx ? q4 : q0;
  assign curR        = useAppx ? r4 : r0;
  assign curDz       = useAppx ? dz4 : dz0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference from the arithmetic definition: shortcuts first, then
  // quotient of the top (32-k) dividend bits, remainder from |a|-|q|*|b|.
  function automatic void refModel(input int k, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] eq, output logic [31:0] er,
                                   output logic edz, output int elat);
    longint sa, sb, ma, mb, qt, mq, mr, qv, rv;
    bit neg;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ma  = (sa < 0) ? -sa : sa;
    mb  = (sb < 0) ? -sb : sb;
    neg = (sa < 0) != (sb < 0);
    edz = 1'b0;
    if (sb == 0) begin
      eq = (sa < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      er = a;
      edz = 1'b1;
      elat = 1;
    end else if (sa == 0) begin
      eq = 32'd0;
      er = 32'd0;
      elat = 1;
    end else if (mb == 1) begin
      qv = neg ? -ma : ma;
      eq = (qv == 64'sd2147483648) ? 32'h7FFF_FFFF : qv[31:0];
      er = 32'd0;
      elat = 1;
    end else begin
      qt = (ma >> k) / mb;
      mq = qt << k;
      mr = ma - mq * mb;
      qv = neg ? -mq : mq;
      rv = (sa < 0) ? -mr : mr;
      eq = qv[31:0];
      er = rv[31:0];
      elat = 32 - k + 1;
    end
  endfunction

  task automatic applyStimulus(input logic selAppx, input logic [31:0] aIn, input logic [31:0] bIn,
                               input logic [31:0] expQ, input logic [31:0] expR,
                               input logic expDz, input int expLat, input string tag);
    int waitCnt;
    int lat;
    bit seen;
    useAppx = selAppx;
    @(negedge clk);
    waitCnt = 0;
    while (!curInReady && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!curInReady) begin
      checkOutput({tag, " in_ready_timeout"}, 32'd0, 32'd1);
      return;
    end
    aDrv    = aIn;
    bDrv    = bIn;
    inValid = 1'b1;
    @(posedge clk);
    #1 inValid = 1'b0;
    seen = 1'b0;
    lat  = 0;
    for (int n = 1; n <= 100 && !seen; n++) begin
      @(negedge clk);
      if (curOutValid) begin
        seen = 1'b1;
        lat  = n;
      end
    end
    if (!seen) begin
      checkOutput({tag, " out_valid_timeout"}, 32'd0, 32'd1);
      return;
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, " q"}, curQ, expQ);
    checkOutput({tag, " r"}, curR, expR);
    checkOutput({tag, " dz"}, {31'd0, curDz}, {31'd0, expDz});
    outReady = 1'b1;
    @(posedge clk);
    #1 outReady = 1'b0;
  endtask

  initial begin
    logic [31:0] eq, er, ra, rb;
    logic        edz;
    int          elat;
    int          sel;
    int          outSeen;

    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b0;
    useAppx  = 1'b0;
    aDrv     = '0;
    bDrv     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset out_valid", {31'd0, outValid0}, 32'd0);
    checkOutput("reset in_ready", {31'd0, inReady0}, 32'd1);
    checkOutput("reset q", q0, 32'd0);
    checkOutput("reset r", r0, 32'd0);
    checkOutput("reset dz", {31'd0, dz0}, 32'd0);
    checkOutput("reset in_ready appx", {31'd0, inReady4}, 32'd1);
    rst = 1'b0;

    applyStimulus(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, "pos_pos");
    applyStimulus(1'b0, -32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33, "neg_pos");
    applyStimulus(1'b0, 32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0, 33, "pos_neg");
    applyStimulus(1'b1, 32'd1000, 32'd3, 32'd320, 32'd40, 1'b0, 29, "appx4");
    applyStimulus(1'b0, 32'd5, 32'd0, 32'h7FFF_FFFF, 32'd5, 1'b1, 1, "div0_pos");
    applyStimulus(1'b0, -32'sd5, 32'd0, 32'h8000_0000, 32'hFFFF_FFFB, 1'b1, 1, "div0_neg");
    applyStimulus(1'b0, 32'd0, 32'd9, 32'd0, 32'd0, 1'b0, 1, "zero_a");
    applyStimulus(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd0, 1'b0, 1, "sat");
    applyStimulus(1'b0, -32'sd8, 32'd1, 32'hFFFF_FFF8, 32'd0, 1'b0, 1, "unit_b");
    applyStimulus(1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 1, "appx_unit_min");

    // Random operands on both instances against the reference.
    for (int i = 0; i < 60; i++) begin
      sel = i % 2;
      ra  = $urandom;
      sel = sel;
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1:       rb = 32'($signed($urandom_range(0, 6)) - 3);
        2:       begin rb = $urandom; ra = 32'h8000_0000; end
        default: begin
          rb = $urandom >> $urandom_range(0, 30);
          if ($urandom_range(0, 1) == 1) rb = -rb;
        end
      endcase
      refModel((sel == 1) ? 4 : 0, ra, rb, eq, er, edz, elat);
      applyStimulus(sel[0], ra, rb, eq, er, edz, elat, "random");
    end

    // Backpressure: hold the result while new operands are offered.
    useAppx = 1'b0;
    refModel(0, 32'd123456, 32'd789, eq, er, edz, elat);
    @(negedge clk);
    aDrv = 32'd123456;
    bDrv = 32'd789;
    inValid = 1'b1;
    @(posedge clk);
    #1 inValid = 1'b0;
    outSeen = 0;
    for (int n = 0; n < 100 && outSeen == 0; n++) begin
      @(negedge clk);
      if (outValid0) outSeen = 1;
    end
    checkOutput("bp out_valid", 32'(outSeen), 32'd1);
    for (int n = 0; n < 5; n++) begin
      aDrv = 32'd77;
      bDrv = 32'd5;
      inValid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("bp hold valid", {31'd0, outValid0}, 32'd1);
      checkOutput("bp in_ready", {31'd0, inReady0}, 32'd0);
      checkOutput("bp q", q0, eq);
      checkOutput("bp r", r0, er);
    end
    inValid = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    #1 outReady = 1'b0;
    @(negedge clk);
    checkOutput("bp no queued valid", {31'd0, outValid0}, 32'd0);
    checkOutput("bp idle ready", {31'd0, inReady0}, 32'd1);

    // Reset mid-calculation aborts and produces nothing.
    @(negedge clk);
    aDrv = 32'd1000;
    bDrv = 32'd3;
    inValid = 1'b1;
    @(posedge clk);
    #1 inValid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst out_valid", {31'd0, outValid0}, 32'd0);
    checkOutput("rst in_ready", {31'd0, inReady0}, 32'd1);
    outSeen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (outValid0) outSeen = 1;
    end
    checkOutput("rst no result", 32'(outSeen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/signed_div32_appx_iter.md
Name: signed_div32_appx_iter

Overview:
- Iterative signed 32-bit divider for the approximate-arithmetic functional-unit library. It is the inverse-direction companion to the approximate multiplier used in the JPEG flow.
- Uses restoring division with a configurable number of quotient LSBs skipped. Skipping LSBs trades accuracy for latency.
- Special-cases zero operands and unit divisor in one cycle, mirroring the multiplier's shortcut paths.
- Valid/ready handshake on both input and output, so it drops into the same datapath slots as other multi-cycle FUs.

Parameters:
- WIDTH, 32, operand/result width in bits.
- APPX_BITS, 0, number of quotient LSBs not computed and forced to zero. Legal range is 0..WIDTH-1. 0 means exact.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  dividend, two's complement
- b  input  WIDTH  divisor, two's complement
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- q  output  WIDTH  quotient, two's complement, truncated toward zero
- r  output  WIDTH  remainder, carries the sign of a
- div_by_zero  output  1  flag, qualified by out_valid

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, q=0, r=0, div_by_zero=0. in_ready=1, since it is decoded from state==IDLE.
- Reset mid-operation: in-flight division is aborted and no result is produced.
- States and transitions:
  - IDLE: in_ready=1. Accept occurs when in_valid&in_ready.
  - On accept, latch |a|, |b|, sign_q=a[MSB]^b[MSB], sign_r=a[MSB]. Then:
    - b==0: next state DONE. q=0x7FFF_FFFF if a>=0 else 0x8000_0000; r=a; div_by_zero=1.
    - else a==0: next state DONE, q=0, r=0.
    - else |b|==1: next state DONE. q=sign-adjusted a, saturating 0x8000_0000/-1 to 0x7FFF_FFFF; r=0.
    - else: next state CALC with iteration counter=ITER-1, where ITER=WIDTH-APPX_BITS.
  - CALC: each cycle runs one restoring step on the next dividend bit, MSB first.
    - partial remainder P=(P<<1)|dividend_bit.
    - If P>=|b|, then P-=|b| and the quotient bit is 1.
    - After ITER steps, next state DONE.
  - DONE: out_valid=1. Outputs hold stable until out_ready. On out_valid&out_ready, next state IDLE.
- Latency from the accept edge to out_valid: 1 cycle for the special cases, ITER+1 cycles otherwise. Throughput is one operation in flight.
- Truncated result:
  - |q| = quotient_top<<APPX_BITS, so the low APPX_BITS bits are zero.
  - |r| = (P<<APPX_BITS) | |a|[APPX_BITS-1:0]. This always satisfies |a|=|q|*|b|+|r|. |r| may be >=|b| when APPX_BITS>0.
- Sign application: q negated if sign_q. r negated if sign_r.
- Width rules:
  - |x| of 0x8000_0000 is 2^31, held in an unsigned WIDTH-bit register.
  - P is WIDTH+1 bits internally.
- Handshake rules:
  - in_ready=0 in CALC and DONE. Operands presented then are ignored and not queued.
  - out_valid never deasserts without out_ready.
  - No combinational path from in_valid to out_valid.

Decomposition:
- Shared package div32appx_pkg holds:
  - the state enum {IDLE, CALC, DONE};
  - the saturation constants QMAX=0x7FFF_FFFF and QMIN=0x8000_0000;
  - a function computing ITER from WIDTH/APPX_BITS.
- Sub-module div32appx_step is natural. It is a combinational single restoring step: inputs P, dividend bit, divisor; outputs next P and quotient bit.

Test Plan:
1. APPX_BITS=0, a=100, b=7 -> q=14, r=2, div_by_zero=0, out_valid exactly 33 cycles after accept.
2. APPX_BITS=0, a=-100, b=7 -> q=-14 (0xFFFF_FFF2), r=-2. Also a=100, b=-7 -> q=-14, r=2.
3. APPX_BITS=4, a=1000, b=3 -> q=320, r=40 (exact 333/1), out_valid 29 cycles after accept.
4. a=5, b=0 -> q=0x7FFF_FFFF, r=5, div_by_zero=1, 1-cycle latency. a=0, b=9 -> q=0, r=0, 1 cycle.
5. a=0x8000_0000, b=0xFFFF_FFFF -> q=0x7FFF_FFFF, r=0. Also a=-8, b=1 -> q=-8, r=0, 1 cycle.
6. Backpressure and reset:
   - Hold out_ready=0 for 5 cycles in DONE: q/r stable, in_ready=0, extra in_valid ignored.
   - Assert rst mid-CALC: next cycle out_valid=0, in_ready=1, no result emitted.
